// File: rtl/oam_dma_ctrl_pkg.sv
// Shared encodings and address constants for the OAM DMA initiator.
package oam_dma_ctrl_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE  = 3'd0,
      DMA_REQ   = 3'd1,
      DMA_READ  = 3'd2,
      DMA_WRITE = 3'd3,
      DMA_DONE  = 3'd4
   } dma_state_t;

   localparam logic [15:0] OAM_BASE       = 16'hFE00;
   localparam logic [7:0]  OAM_SIZE       = 8'hA0;
   localparam logic [7:0]  DMA_REG_OFFSET = 8'h46;
   localparam logic [7:0]  ECHO_PAGE_LO   = 8'hE0;

   // Echo RAM pages E0..FF alias work RAM C0..DF.
   function automatic logic [7:0] remap_page(input logic [7:0] page);
      return (page >= ECHO_PAGE_LO) ? (page - 8'h20) : page;
   endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA bus initiator: copies NUM_BYTES from {page,00} to DEST_BASE
// as alternating read/write cycles while holding the arbiter grant.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transfer; bus released
// REQ     | requesting bus; waits for bus_gnt
// READ    | driving source address with OE; latches data into dbuf
// WRITE   | driving dbuf to DEST_BASE+idx with WE
// DONE    | one-cycle completion pulse, then IDLE
module oam_dma_ctrl
   import oam_dma_ctrl_pkg::*;
#(
   parameter int          NUM_BYTES = int'(OAM_SIZE),
   parameter logic [15:0] DEST_BASE = OAM_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_trigger,
   input  logic [7:0]  dma_page,
   input  logic        bus_gnt,
   output logic        bus_req,
   output logic [15:0] mem_addr,
   inout  wire  [7:0]  mem_data,
   output logic        mem_oe,
   output logic        mem_we,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE  = DMA_IDLE;
   localparam logic [2:0] S_REQ   = DMA_REQ;
   localparam logic [2:0] S_READ  = DMA_READ;
   localparam logic [2:0] S_WRITE = DMA_WRITE;
   localparam logic [2:0] S_DONE  = DMA_DONE;

   localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

   logic [2:0] state;
   logic [7:0] src_page;
   logic [7:0] idx;
   logic [7:0] dbuf;

   // A trigger in any state restarts from byte 0; it outranks completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         src_page <= 8'h00;
         idx      <= 8'h00;
         dbuf     <= 8'h00;
      end else if (dma_trigger) begin
         state    <= S_REQ;
         src_page <= remap_page(dma_page);
         idx      <= 8'h00;
      end else begin
         case (state)
            S_REQ: begin
               if (bus_gnt) state <= S_READ;
            end
            S_READ: begin
               if (bus_gnt) begin
                  dbuf  <= mem_data;
                  state <= S_WRITE;
               end else begin
                  state <= S_REQ;
               end
            end
            S_WRITE: begin
               if (!bus_gnt) begin
                  state <= S_REQ;
               end else if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 8'h01;
                  state <= S_READ;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus_req  = 1'b0;
      mem_oe   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = 16'h0000;
      busy     = (state != S_IDLE);
      done     = 1'b0;
      case (state)
         S_REQ:   bus_req = 1'b1;
         S_READ: begin
            bus_req  = 1'b1;
            mem_oe   = 1'b1;
            mem_addr = {src_page, idx};
         end
         S_WRITE: begin
            bus_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = DEST_BASE + {8'h00, idx};
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign mem_data = (state == S_WRITE) ? dbuf : 8'hzz;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: behavioural memory responder plus a scoreboard of
// expected OAM writes, exercised by one task per scenario.
module tb_oam_dma_ctrl;
   localparam int N = 160;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dma_trigger = 1'b0;
   logic [7:0]  dma_page = 8'h00;
   logic        bus_gnt = 1'b0;
   logic        bus_req, mem_oe, mem_we, busy, done;
   logic [15:0] mem_addr;
   wire  [7:0]  mem_data;

   logic [7:0]  ram [0:65535];
   logic [15:0] exp_addr [$];
   logic [7:0]  exp_data [$];
   logic [15:0] ea;
   logic [7:0]  ed;
   logic [15:0] rd_min, rd_max;
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;

   oam_dma_ctrl #(.NUM_BYTES(N), .DEST_BASE(16'hFE00)) dut (
      .clk(clk), .rst(rst), .dma_trigger(dma_trigger), .dma_page(dma_page),
      .bus_gnt(bus_gnt), .bus_req(bus_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_oe(mem_oe), .mem_we(mem_we),
      .busy(busy), .done(done)
   );

   // Memory responder: asynchronous read, write on the clock edge.
   assign mem_data = (bus_gnt && mem_oe && !mem_we) ? ram[mem_addr] : 8'hzz;

   always @(posedge clk) begin
      if (!rst && bus_gnt && mem_we && !dma_trigger) begin
         checks++;
         if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: write addr=%h data=%h, required no write", mem_addr, mem_data);
         end else begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (mem_addr !== ea || mem_data !== ed) begin
               errors++;
               $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_data, ea, ed);
            end
         end
      end
      if (bus_gnt && mem_we) ram[mem_addr] = mem_data;
      if (bus_gnt && mem_oe) begin
         if (mem_addr < rd_min) rd_min = mem_addr;
         if (mem_addr > rd_max) rd_max = mem_addr;
      end
      if (done) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [15:0] src);
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < N; i++) begin
         exp_addr.push_back(16'hFE00 + 16'(i));
         exp_data.push_back(ram[src + 16'(i)]);
      end
      for (int i = 0; i < N; i++) ram[16'hFE00 + 16'(i)] = 8'h00;
   endtask

   task automatic fire(input logic [7:0] page);
      dma_page = page;
      dma_trigger = 1'b1;
      step();
      dma_trigger = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max; k++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({bus_req, mem_oe, mem_we, busy, done} !== 5'b0 || mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: req/oe/we/busy/done=%b addr=%h, required 00000 addr=0000",
                  {bus_req, mem_oe, mem_we, busy, done}, mem_addr);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int busy_cnt = 0, done_seen = 0, done_cyc = -1, bad = 0;
      for (int i = 0; i < N; i++) ram[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      push_exp(16'hC100);
      bus_gnt = 1'b1;
      rd_min = 16'hFFFF;
      rd_max = 16'h0000;
      fire(8'hC1);
      for (int c = 1; c <= 330; c++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_seen++;
            done_cyc = c;
         end
         if (c == 2) begin
            checks++;
            if (!(mem_oe && !mem_we && mem_addr == 16'hC100)) begin
               errors++;
               $display("FAIL basic_first_read: oe=%b we=%b addr=%h, required oe=1 we=0 addr=c100",
                        mem_oe, mem_we, mem_addr);
            end
         end
         step();
      end
      checks++;
      if (done_cyc != 322 || done_seen != 1) begin
         errors++;
         $display("FAIL basic_done: cycle=%0d pulses=%0d, required cycle=322 pulses=1", done_cyc, done_seen);
      end
      checks++;
      if (busy_cnt != 322) begin
         errors++;
         $display("FAIL basic_busy: cycles=%0d, required 322", busy_cnt);
      end
      checks++;
      if (busy !== 1'b0 || bus_req !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: busy=%b req=%b, required 0 0", busy, bus_req);
      end
      for (int i = 0; i < N; i++) if (ram[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
      checks++;
      if (bad != 0 || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL basic_oam: bad=%0d pending=%0d, required 0 0", bad, exp_addr.size());
      end
   endtask

   task automatic test_echo();
      bit ok;
      for (int i = 0; i < N; i++) begin
         ram[16'hC300 + 16'(i)] = ~8'(i);
         ram[16'hE300 + 16'(i)] = 8'hEE;
      end
      push_exp(16'hC300);
      bus_gnt = 1'b1;
      rd_min = 16'hFFFF;
      rd_max = 16'h0000;
      fire(8'hE3);
      wait_done(400, ok);
      checks++;
      if (!ok || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL echo_done: done=%b pending=%0d, required 1 0", ok, exp_addr.size());
      end
      checks++;
      if (rd_min !== 16'hC300 || rd_max !== 16'hC39F) begin
         errors++;
         $display("FAIL echo_range: min=%h max=%h, required c300 c39f", rd_min, rd_max);
      end
   endtask

   task automatic test_gnt_hold();
      bit ok;
      int bad = 0;
      for (int i = 0; i < N; i++) ram[16'hC500 + 16'(i)] = 8'(i + 3);
      push_exp(16'hC500);
      bus_gnt = 1'b0;
      fire(8'hC5);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (!(bus_req && busy && !mem_oe && !mem_we)) begin
            errors++;
            $display("FAIL hold_req[%0d]: req=%b busy=%b oe=%b we=%b, required 1 1 0 0",
                     k, bus_req, busy, mem_oe, mem_we);
         end
         step();
      end
      bus_gnt = 1'b1;
      wait_done(400, ok);
      for (int i = 0; i < N; i++) if (ram[16'hFE00 + 16'(i)] !== 8'(i + 3)) bad++;
      checks++;
      if (!ok || bad != 0 || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL hold_complete: done=%b bad=%0d pending=%0d, required 1 0 0", ok, bad, exp_addr.size());
      end
   endtask

   task automatic test_gnt_drop();
      bit ok, found = 1'b0;
      for (int i = 0; i < N; i++) ram[16'hC700 + 16'(i)] = 8'(i * 7);
      push_exp(16'hC700);
      bus_gnt = 1'b1;
      fire(8'hC7);
      for (int k = 0; k < 200; k++) begin
         if (mem_we && mem_addr == 16'hFE32) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL drop_reach: write of idx 50 seen=%b, required 1", found);
      end
      bus_gnt = 1'b0;
      step();
      checks++;
      if (!(bus_req && !mem_oe && !mem_we)) begin
         errors++;
         $display("FAIL drop_req: req=%b oe=%b we=%b, required 1 0 0", bus_req, mem_oe, mem_we);
      end
      step();
      step();
      bus_gnt = 1'b1;
      step();
      checks++;
      if (!(mem_oe && mem_addr == 16'hC732)) begin
         errors++;
         $display("FAIL drop_resume: oe=%b addr=%h, required oe=1 addr=c732", mem_oe, mem_addr);
      end
      wait_done(400, ok);
      checks++;
      if (!ok || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL drop_complete: done=%b pending=%0d, required 1 0", ok, exp_addr.size());
      end
   endtask

   task automatic test_retrigger();
      bit ok, found = 1'b0;
      int bad = 0;
      for (int i = 0; i < N; i++) ram[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
      push_exp(16'hC100);
      bus_gnt = 1'b1;
      done_cnt = 0;
      fire(8'hC1);
      for (int k = 0; k < 300; k++) begin
         if (mem_oe && mem_addr == 16'hC164) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL retrig_reach: read of idx 100 seen=%b, required 1", found);
      end
      fire(8'hD0);
      push_exp(16'hD000);
      checks++;
      if (!(bus_req && busy && !mem_oe && !mem_we && !done)) begin
         errors++;
         $display("FAIL retrig_req: req=%b busy=%b oe=%b we=%b done=%b, required 1 1 0 0 0",
                  bus_req, busy, mem_oe, mem_we, done);
      end
      wait_done(400, ok);
      for (int i = 0; i < N; i++) if (ram[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) bad++;
      checks++;
      if (!ok || done_cnt != 1 || bad != 0 || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL retrig_complete: done=%b pulses=%0d bad=%0d pending=%0d, required 1 1 0 0",
                  ok, done_cnt, bad, exp_addr.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok, found = 1'b0;
      for (int i = 0; i < N; i++) ram[16'hC200 + 16'(i)] = 8'(i + 8'h11);
      push_exp(16'hC200);
      bus_gnt = 1'b1;
      fire(8'hC2);
      for (int k = 0; k < 300; k++) begin
         if (mem_oe && mem_addr == 16'hC250) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rstmid_reach: read of idx 80 seen=%b, required 1", found);
      end
      done_cnt = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({bus_req, mem_oe, mem_we, busy, done} !== 5'b0 || mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL rstmid_outputs: req/oe/we/busy/done=%b addr=%h, required 00000 addr=0000",
                  {bus_req, mem_oe, mem_we, busy, done}, mem_addr);
      end
      for (int k = 0; k < 5; k++) step();
      checks++;
      if (busy !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: busy=%b pulses=%0d, required 0 0", busy, done_cnt);
      end
      push_exp(16'hC200);
      fire(8'hC2);
      wait_done(400, ok);
      checks++;
      if (!ok || done_cnt != 1 || exp_addr.size() != 0) begin
         errors++;
         $display("FAIL rstmid_fresh: done=%b pulses=%0d pending=%0d, required 1 1 0",
                  ok, done_cnt, exp_addr.size());
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
      rd_min = 16'hFFFF;
      rd_max = 16'h0000;
      test_reset();
      test_basic();
      test_echo();
      test_gnt_hold();
      test_gnt_drop();
      test_retrigger();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
